// File: rtl/avalon_msg_length_limiter_if.sv
// Avalon-ST stream bundle shared by the message length limiter and its neighbours.
// Carries data/valid/rdy/sop/eop/empty. empty is log2up_func(DATA_WIDTH_IN_BYTES) bits.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    function automatic int unsigned log2up_func(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    localparam int unsigned EMPTY_W = log2up_func(DATA_WIDTH_IN_BYTES);

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;

    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_msg_length_limiter.sv
// Avalon-ST message length limiter.
// Passes sop..eop framed messages through one registered output stage and cuts any
// message longer than MAX_MSG_BEATS with a forced eop, draining the remaining tail.
// Each truncation raises a one-cycle too_long_error pulse alongside the cut eop beat.
// Optional statistics counters: define AVALON_MSG_LENGTH_LIMITER_STATS_EN to build
// msg_count / truncated_count; otherwise both outputs are tied to zero.
module avalon_msg_length_limiter #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_MSG_BEATS       = 64
) (
    input  logic        clk,
    input  logic        rst,
    avalon_st_if.slave  in_msg,
    avalon_st_if.master out_msg,
    output logic        too_long_error,
    output logic [15:0] msg_count,
    output logic [15:0] truncated_count
);

    function automatic int unsigned log2up_func(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    localparam int unsigned EMPTY_W     = log2up_func(DATA_WIDTH_IN_BYTES);
    localparam int unsigned DATA_W      = 8 * DATA_WIDTH_IN_BYTES;
    localparam int unsigned CNT_W       = log2up_func(MAX_MSG_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_MSG_BEATS - 1);
    localparam logic        SINGLE_BEAT = 1'(MAX_MSG_BEATS == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PASS,
        S_DROP
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [CNT_W-1:0]   r_beat_cnt;
    logic               r_valid;
    logic               r_sop;
    logic               r_eop;
    logic [EMPTY_W-1:0] r_empty;
    logic [DATA_W-1:0]  r_data;
    logic               r_err;

    logic               w_out_free;
    logic               w_rdy;
    logic               w_accept;
    logic               w_emit;
    logic               w_out_sop;
    logic               w_out_eop;
    logic               w_trunc;
    logic               w_last_beat;
    logic [EMPTY_W-1:0] w_out_empty;

    assign w_out_free  = ~r_valid | out_msg.rdy;
    assign w_last_beat = (r_beat_cnt == LAST_CNT);
    assign w_accept    = in_msg.valid & w_rdy;
    // A cut eop has no input eop, so its empty is forced to zero here as well.
    assign w_out_empty = (in_msg.eop & w_out_eop) ? in_msg.empty : '0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_emit && !in_msg.eop) begin
                    w_next_state = SINGLE_BEAT ? S_DROP : S_PASS;
                end
            end
            S_PASS: begin
                if (w_emit) begin
                    if (in_msg.eop) begin
                        w_next_state = S_IDLE;
                    end else if (w_last_beat) begin
                        w_next_state = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (w_accept && in_msg.eop) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Per-state handshake and beat rewrite decisions
    always_comb begin
        w_rdy     = w_out_free;
        w_emit    = 1'b0;
        w_out_sop = 1'b0;
        w_out_eop = 1'b0;
        w_trunc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_emit    = in_msg.valid & w_out_free & in_msg.sop;
                w_out_sop = 1'b1;
                w_out_eop = in_msg.eop | SINGLE_BEAT;
                w_trunc   = w_emit & ~in_msg.eop & SINGLE_BEAT;
            end
            S_PASS: begin
                w_emit    = in_msg.valid & w_out_free;
                w_out_eop = in_msg.eop | w_last_beat;
                w_trunc   = w_emit & ~in_msg.eop & w_last_beat;
            end
            S_DROP: begin
                w_rdy = 1'b1;
            end
            default: begin
                w_rdy = w_out_free;
            end
        endcase
    end

    // Output stage, error pulse and beat counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_empty    <= '0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            if (w_emit) begin
                r_valid <= 1'b1;
                r_sop   <= w_out_sop;
                r_eop   <= w_out_eop;
                r_empty <= w_out_empty;
                r_data  <= in_msg.data;
            end else if (out_msg.rdy) begin
                r_valid <= 1'b0;
            end
            r_err <= w_trunc;
            if (w_emit && (r_state == S_IDLE)) begin
                r_beat_cnt <= CNT_W'(1);
            end else if (w_emit && (r_state == S_PASS)) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
        end
    end

`ifdef AVALON_MSG_LENGTH_LIMITER_STATS_EN
    logic [15:0] r_msg_count;
    logic [15:0] r_truncated_count;

    // Saturating counters of delivered and truncated messages
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_msg_count       <= '0;
            r_truncated_count <= '0;
        end else begin
            if (r_valid && out_msg.rdy && r_eop && (r_msg_count != '1)) begin
                r_msg_count <= r_msg_count + 16'd1;
            end
            if (r_err && (r_truncated_count != '1)) begin
                r_truncated_count <= r_truncated_count + 16'd1;
            end
        end
    end

    assign msg_count       = r_msg_count;
    assign truncated_count = r_truncated_count;
`else
    assign msg_count       = '0;
    assign truncated_count = '0;
`endif

    assign in_msg.rdy     = w_rdy;
    assign out_msg.valid  = r_valid;
    assign out_msg.sop    = r_sop;
    assign out_msg.eop    = r_eop;
    assign out_msg.empty  = r_empty;
    assign out_msg.data   = r_data;
    assign too_long_error = r_err;

endmodule

// File: tb/tb_avalon_msg_length_limiter.sv
// Directed bench for avalon_msg_length_limiter: one instance with MAX_MSG_BEATS=4,
// one with MAX_MSG_BEATS=1. Inputs change and outputs are sampled on the falling edge.
module tb_avalon_msg_length_limiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

`ifdef AVALON_MSG_LENGTH_LIMITER_STATS_EN
    localparam int STATS_ON = 1;
`else
    localparam int STATS_ON = 0;
`endif

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) a_in ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) a_out ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) b_in ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) b_out ();

    logic        a_err, b_err;
    logic [15:0] a_msgs, a_trunc, b_msgs, b_trunc;

    avalon_msg_length_limiter #(.DATA_WIDTH_IN_BYTES(16), .MAX_MSG_BEATS(4)) dut_a (
        .clk(clk), .rst(rst), .in_msg(a_in), .out_msg(a_out),
        .too_long_error(a_err), .msg_count(a_msgs), .truncated_count(a_trunc)
    );

    avalon_msg_length_limiter #(.DATA_WIDTH_IN_BYTES(16), .MAX_MSG_BEATS(1)) dut_b (
        .clk(clk), .rst(rst), .in_msg(b_in), .out_msg(b_out),
        .too_long_error(b_err), .msg_count(b_msgs), .truncated_count(b_trunc)
    );

    // Observed output beat packed as {valid, sop, eop, empty[3:0], data[7:0]}
    logic [14:0] obs_a, obs_b;
    assign obs_a = {a_out.valid, a_out.sop, a_out.eop, a_out.empty, a_out.data[7:0]};
    assign obs_b = {b_out.valid, b_out.sop, b_out.eop, b_out.empty, b_out.data[7:0]};

    function automatic logic [14:0] pk(input logic v, input logic s, input logic e,
                                       input logic [3:0] em, input logic [7:0] d);
        return {v, s, e, em, d};
    endfunction

    task automatic drv_a(input logic v, input logic s, input logic e,
                         input logic [3:0] em, input logic [7:0] d);
        a_in.valid = v; a_in.sop = s; a_in.eop = e; a_in.empty = em; a_in.data = {120'd0, d};
    endtask

    task automatic drv_b(input logic v, input logic s, input logic e,
                         input logic [3:0] em, input logic [7:0] d);
        b_in.valid = v; b_in.sop = s; b_in.eop = e; b_in.empty = em; b_in.data = {120'd0, d};
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drv_a(0, 0, 0, 0, 0);
        drv_b(0, 0, 0, 0, 0);
        a_out.rdy = 1'b1;
        b_out.rdy = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (obs_a !== 15'd0) begin failures++; $display("FAIL reset_out_a got=%h exp=%h", obs_a, 15'd0); end
        checks++; if (obs_b !== 15'd0) begin failures++; $display("FAIL reset_out_b got=%h exp=%h", obs_b, 15'd0); end
        checks++; if ({a_err, b_err, a_msgs, a_trunc, b_msgs, b_trunc} !== 66'd0) begin failures++;
            $display("FAIL reset_err_counts got=%b/%b/%h/%h/%h/%h exp=all zero", a_err, b_err, a_msgs, a_trunc, b_msgs, b_trunc); end
        checks++; if ({a_in.rdy, b_in.rdy} !== 2'b11) begin failures++; $display("FAIL reset_in_rdy got=%b exp=%b", {a_in.rdy, b_in.rdy}, 2'b11); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (a_in.rdy !== 1'b1) begin failures++; $display("FAIL post_reset_in_rdy got=%b exp=1", a_in.rdy); end
    endtask

    task automatic test_pass_through();
        drv_a(1, 1, 0, 0, 8'h11);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 1, 0, 0, 8'h11)) begin failures++; $display("FAIL pass_b1 got=%h exp=%h", obs_a, pk(1, 1, 0, 0, 8'h11)); end
        drv_a(1, 0, 0, 0, 8'h12);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 0, 0, 8'h12)) begin failures++; $display("FAIL pass_b2 got=%h exp=%h", obs_a, pk(1, 0, 0, 0, 8'h12)); end
        drv_a(1, 0, 1, 5, 8'h13);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 1, 5, 8'h13)) begin failures++; $display("FAIL pass_b3 got=%h exp=%h", obs_a, pk(1, 0, 1, 5, 8'h13)); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL pass_err got=%b exp=0", a_err); end
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (a_out.valid !== 1'b0) begin failures++; $display("FAIL pass_idle_valid got=%b exp=0", a_out.valid); end
    endtask

    task automatic test_exact_length();
        drv_a(1, 1, 0, 0, 8'h21);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 1, 0, 0, 8'h21)) begin failures++; $display("FAIL exact_b1 got=%h exp=%h", obs_a, pk(1, 1, 0, 0, 8'h21)); end
        drv_a(1, 0, 0, 0, 8'h22);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 0, 0, 8'h22)) begin failures++; $display("FAIL exact_b2 got=%h exp=%h", obs_a, pk(1, 0, 0, 0, 8'h22)); end
        drv_a(1, 0, 0, 0, 8'h23);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 0, 0, 8'h23)) begin failures++; $display("FAIL exact_b3 got=%h exp=%h", obs_a, pk(1, 0, 0, 0, 8'h23)); end
        drv_a(1, 0, 1, 1, 8'h24);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 1, 1, 8'h24)) begin failures++; $display("FAIL exact_b4 got=%h exp=%h", obs_a, pk(1, 0, 1, 1, 8'h24)); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL exact_err got=%b exp=0", a_err); end
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (a_out.valid !== 1'b0) begin failures++; $display("FAIL exact_idle_valid got=%b exp=0", a_out.valid); end
        checks++; if (a_msgs !== 16'(2 * STATS_ON)) begin failures++; $display("FAIL exact_msg_count got=%0d exp=%0d", a_msgs, 2 * STATS_ON); end
    endtask

    task automatic test_truncation();
        drv_a(1, 1, 0, 0, 8'h31);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 1, 0, 0, 8'h31)) begin failures++; $display("FAIL trunc_b1 got=%h exp=%h", obs_a, pk(1, 1, 0, 0, 8'h31)); end
        drv_a(1, 0, 0, 0, 8'h32);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 0, 0, 8'h32)) begin failures++; $display("FAIL trunc_b2 got=%h exp=%h", obs_a, pk(1, 0, 0, 0, 8'h32)); end
        drv_a(1, 0, 0, 0, 8'h33);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 0, 0, 8'h33)) begin failures++; $display("FAIL trunc_b3 got=%h exp=%h", obs_a, pk(1, 0, 0, 0, 8'h33)); end
        checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL trunc_early_err got=%b exp=0", a_err); end
        drv_a(1, 0, 0, 0, 8'h34);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 1, 0, 8'h34)) begin failures++; $display("FAIL trunc_cut_beat got=%h exp=%h", obs_a, pk(1, 0, 1, 0, 8'h34)); end
        checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL trunc_err_pulse got=%b exp=1", a_err); end
        drv_a(1, 0, 0, 0, 8'h35);
        @(negedge clk);
        checks++; if ({a_out.valid, a_err, a_in.rdy} !== 3'b001) begin failures++; $display("FAIL trunc_drain5 got=%b exp=%b", {a_out.valid, a_err, a_in.rdy}, 3'b001); end
        drv_a(1, 0, 0, 0, 8'h36);
        @(negedge clk);
        checks++; if ({a_out.valid, a_in.rdy} !== 2'b01) begin failures++; $display("FAIL trunc_drain6 got=%b exp=%b", {a_out.valid, a_in.rdy}, 2'b01); end
        drv_a(1, 0, 1, 3, 8'h37);
        @(negedge clk);
        checks++; if (a_out.valid !== 1'b0) begin failures++; $display("FAIL trunc_drain7 got=%b exp=0", a_out.valid); end
        checks++; if (a_trunc !== 16'(STATS_ON)) begin failures++; $display("FAIL trunc_count got=%0d exp=%0d", a_trunc, STATS_ON); end
        drv_a(1, 1, 1, 2, 8'h38);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 1, 1, 2, 8'h38)) begin failures++; $display("FAIL trunc_next_msg got=%h exp=%h", obs_a, pk(1, 1, 1, 2, 8'h38)); end
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (a_msgs !== 16'(4 * STATS_ON)) begin failures++; $display("FAIL trunc_msg_count got=%0d exp=%0d", a_msgs, 4 * STATS_ON); end
    endtask

    task automatic test_backpressure();
        a_out.rdy = 1'b1;
        drv_a(1, 1, 0, 0, 8'h41);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 1, 0, 0, 8'h41)) begin failures++; $display("FAIL bp_b1 got=%h exp=%h", obs_a, pk(1, 1, 0, 0, 8'h41)); end
        a_out.rdy = 1'b0;
        drv_a(1, 0, 0, 0, 8'h42);
        #1;
        checks++; if (a_in.rdy !== 1'b0) begin failures++; $display("FAIL bp_in_rdy_low got=%b exp=0", a_in.rdy); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({obs_a, a_in.rdy} !== {pk(1, 1, 0, 0, 8'h41), 1'b0}) begin failures++;
                $display("FAIL bp_hold cycle=%0d got=%h/%b exp=%h/0", i, obs_a, a_in.rdy, pk(1, 1, 0, 0, 8'h41)); end
        end
        a_out.rdy = 1'b1;
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 0, 0, 8'h42)) begin failures++; $display("FAIL bp_b2 got=%h exp=%h", obs_a, pk(1, 0, 0, 0, 8'h42)); end
        drv_a(1, 0, 1, 7, 8'h43);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 1, 7, 8'h43)) begin failures++; $display("FAIL bp_b3 got=%h exp=%h", obs_a, pk(1, 0, 1, 7, 8'h43)); end
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if (a_out.valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", a_out.valid); end
        checks++; if (a_msgs !== 16'(5 * STATS_ON)) begin failures++; $display("FAIL bp_msg_count got=%0d exp=%0d", a_msgs, 5 * STATS_ON); end
    endtask

    task automatic test_max_one();
        drv_b(1, 1, 1, 9, 8'h51);
        @(negedge clk);
        checks++; if (obs_b !== pk(1, 1, 1, 9, 8'h51)) begin failures++; $display("FAIL max1_single got=%h exp=%h", obs_b, pk(1, 1, 1, 9, 8'h51)); end
        checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL max1_single_err got=%b exp=0", b_err); end
        drv_b(1, 1, 0, 0, 8'h52);
        @(negedge clk);
        checks++; if (obs_b !== pk(1, 1, 1, 0, 8'h52)) begin failures++; $display("FAIL max1_cut got=%h exp=%h", obs_b, pk(1, 1, 1, 0, 8'h52)); end
        checks++; if (b_err !== 1'b1) begin failures++; $display("FAIL max1_err_pulse got=%b exp=1", b_err); end
        b_out.rdy = 1'b0;
        drv_b(1, 0, 0, 0, 8'h53);
        #1;
        checks++; if (b_in.rdy !== 1'b1) begin failures++; $display("FAIL max1_drop_rdy got=%b exp=1", b_in.rdy); end
        @(negedge clk);
        checks++; if ({obs_b, b_err} !== {pk(1, 1, 1, 0, 8'h52), 1'b0}) begin failures++;
            $display("FAIL max1_hold got=%h/%b exp=%h/0", obs_b, b_err, pk(1, 1, 1, 0, 8'h52)); end
        b_out.rdy = 1'b1;
        drv_b(1, 0, 1, 4, 8'h54);
        @(negedge clk);
        checks++; if (b_out.valid !== 1'b0) begin failures++; $display("FAIL max1_drained got=%b exp=0", b_out.valid); end
        drv_b(1, 1, 1, 6, 8'h55);
        @(negedge clk);
        checks++; if (obs_b !== pk(1, 1, 1, 6, 8'h55)) begin failures++; $display("FAIL max1_after_drop got=%h exp=%h", obs_b, pk(1, 1, 1, 6, 8'h55)); end
        drv_b(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({b_out.valid, b_msgs, b_trunc} !== {1'b0, 16'(3 * STATS_ON), 16'(STATS_ON)}) begin failures++;
            $display("FAIL max1_counts got=%b/%0d/%0d exp=0/%0d/%0d", b_out.valid, b_msgs, b_trunc, 3 * STATS_ON, STATS_ON); end
    endtask

    task automatic test_reset_mid_message();
        drv_a(1, 1, 0, 0, 8'h61);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 1, 0, 0, 8'h61)) begin failures++; $display("FAIL rstmid_b1 got=%h exp=%h", obs_a, pk(1, 1, 0, 0, 8'h61)); end
        drv_a(1, 0, 0, 0, 8'h62);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({obs_a, a_err, a_msgs, a_trunc} !== 48'd0) begin failures++;
            $display("FAIL rstmid_clear got=%h/%b/%h/%h exp=all zero", obs_a, a_err, a_msgs, a_trunc); end
        checks++; if (a_in.rdy !== 1'b1) begin failures++; $display("FAIL rstmid_in_rdy got=%b exp=1", a_in.rdy); end
        rst = 1'b1;
        drv_a(1, 0, 0, 0, 8'h63);
        @(negedge clk);
        checks++; if (a_out.valid !== 1'b0) begin failures++; $display("FAIL rstmid_tail3 got=%b exp=0", a_out.valid); end
        drv_a(1, 0, 0, 0, 8'h64);
        @(negedge clk);
        checks++; if (a_out.valid !== 1'b0) begin failures++; $display("FAIL rstmid_tail4 got=%b exp=0", a_out.valid); end
        drv_a(1, 0, 1, 3, 8'h65);
        @(negedge clk);
        checks++; if (a_out.valid !== 1'b0) begin failures++; $display("FAIL rstmid_tail5 got=%b exp=0", a_out.valid); end
        drv_a(1, 1, 0, 0, 8'h71);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 1, 0, 0, 8'h71)) begin failures++; $display("FAIL rstmid_new_b1 got=%h exp=%h", obs_a, pk(1, 1, 0, 0, 8'h71)); end
        drv_a(1, 0, 1, 2, 8'h72);
        @(negedge clk);
        checks++; if (obs_a !== pk(1, 0, 1, 2, 8'h72)) begin failures++; $display("FAIL rstmid_new_b2 got=%h exp=%h", obs_a, pk(1, 0, 1, 2, 8'h72)); end
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        checks++; if ({a_out.valid, a_msgs} !== {1'b0, 16'(STATS_ON)}) begin failures++;
            $display("FAIL rstmid_end got=%b/%0d exp=0/%0d", a_out.valid, a_msgs, STATS_ON); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pass_through();
        test_exact_length();
        test_truncation();
        test_backpressure();
        test_max_one();
        test_reset_mid_message();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/avalon_msg_length_limiter.md
# avalon_msg_length_limiter

- Sits directly downstream of the Avalon-ST protocol enforcer and consumes its well-formed stream (sop…eop framed).
- Enforces a maximum message length in beats: any message longer than `MAX_MSG_BEATS` is cut at that beat with a forced eop, and its tail is silently drained.
- Registers the stream through one output stage with full ready/valid backpressure.
- Flags each truncation with a single-cycle error pulse.

## Interface
Parameters:
- `DATA_WIDTH_IN_BYTES`, 16, byte width of `data`; `empty` is `log2up_func(DATA_WIDTH_IN_BYTES)` bits wide.
- `MAX_MSG_BEATS`, 64, maximum accepted beats per message; legal range ≥ 1.

Ports:
- `clk`  input  1  the single clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `in_msg`  `avalon_st_if.slave`  (data, valid, rdy, sop, eop, empty)  stream from the enforcer.
- `out_msg`  `avalon_st_if.master`  (data, valid, rdy, sop, eop, empty)  length-limited stream.
- `too_long_error`  output  1  one-cycle pulse per truncated message.
- `msg_count`  output  16  messages emitted; see Configuration.
- `truncated_count`  output  16  messages truncated; see Configuration.

## Operation
- **Beat counting.** A beat is accepted when `in_msg.valid & in_msg.rdy`. `beat_cnt` is `log2up_func(MAX_MSG_BEATS+1)` bits wide: set to 1 on an accepted sop beat, incremented on every other accepted beat in PASS.
- **IDLE.**
  - `in_msg.rdy = ~out_msg.valid | out_msg.rdy`.
  - Accepted beat with sop is registered to the output. If eop is also set, stay in IDLE; otherwise go to PASS.
  - Accepted beat without sop is discarded: nothing is emitted, no error.
- **PASS.**
  - Same `in_msg.rdy` rule as IDLE.
  - The sop bit is forced to 0 on every registered beat.
  - Beat with eop: emitted unchanged, go to IDLE.
  - Beat that is the `MAX_MSG_BEATS`-th and has no eop: emitted with eop forced to 1 and empty forced to 0; `too_long_error` pulses; go to DROP.
- **DROP.**
  - `in_msg.rdy = 1`.
  - Every accepted beat is discarded.
  - An accepted eop beat returns the block to IDLE.
  - An accepted sop beat is also discarded; DROP exits only on eop.
- **Empty field.** `out_msg.empty` carries `in_msg.empty` only on beats that are eop in both input and output; on all other beats it is 0.
- **Boundary cases.**
  - `MAX_MSG_BEATS`-th beat carrying eop: normal end, no error.
  - `MAX_MSG_BEATS = 1`: a sop-without-eop beat is emitted with sop=1, eop=1 and the block enters DROP.
  - Reset mid-message: all state clears to IDLE; a partial message is not completed on the output.

## Timing
- **Latency.** Exactly 1 cycle from input acceptance to the beat appearing on `out_msg`. Full throughput of one beat per cycle while `out_msg.rdy = 1`.
- **Output hold.** `out_msg.valid`, `data`, `sop`, `eop` and `empty` hold stable while `out_msg.valid & ~out_msg.rdy`.
- **Output register update.** Loads on acceptance of a beat that is emitted. When the current output beat is consumed and no new beat is emitted, `out_msg.valid` clears to 0.
- **Error pulse.** `too_long_error` is registered and high exactly in the first cycle the truncated eop beat is valid on `out_msg`.
- **Reset values.**
  - `out_msg.valid`, `sop`, `eop`, `data`, `empty` all 0.
  - `too_long_error` 0; `msg_count`, `truncated_count` 0.
  - State IDLE, `beat_cnt` 0.
  - `in_msg.rdy` is 1 immediately after reset.

## Configuration
- Macro: `AVALON_MSG_LENGTH_LIMITER_STATS_EN`.
- **Defined:**
  - `msg_count` increments, saturating at 16'hFFFF, on each eop beat consumed on `out_msg` (`valid & rdy & eop`).
  - `truncated_count` increments, saturating, on each `too_long_error` pulse.
- **Undefined:** both outputs are tied to 0 and no counter logic is built. Stream behaviour is identical either way.

## Test plan
- **Pass-through.** `MAX_MSG_BEATS = 4`, 3-beat message (sop beat 1, eop beat 3, empty=5), `out_msg.rdy` constantly 1 → 3 identical beats out, each 1 cycle later; eop beat has empty=5; no error.
- **Exact length.** 4-beat message with eop on beat 4 → 4 beats out unchanged; `too_long_error` stays 0; `msg_count = 1` (stats on).
- **Truncation.** 7-beat message, empty=3 on beat 7 → 4 beats out; beat 4 has eop=1, empty=0; `too_long_error` high one cycle with beat 4; beats 5–7 accepted with `in_msg.rdy = 1` and nothing emitted; `truncated_count = 1`; the next message passes normally.
- **Backpressure.** `out_msg.rdy` low for 5 cycles mid-message → output beat held stable; `in_msg.rdy` low while `out_msg.valid` is 1; no beat lost or duplicated after release.
- **Single beat and `MAX_MSG_BEATS = 1`.** A sop+eop beat passes unchanged. A sop-only beat followed by 2 beats → one beat out with sop=1, eop=1 plus the error pulse; the remaining input is drained.
- **Reset mid-message.** `rst` low during beat 2 of a 5-beat message → next cycle all outputs are 0 and the state is IDLE. After release, a new 2-beat message passes correctly and the remaining non-sop beats of the interrupted message are discarded.
